green_pixel_streamer: RTL
=========================

# green_pixel_streamer

Produces the raster pixel stream (x, y, R, G, B, verde) that the color tracker consumes. It walks a 640x480 frame with blanking, fetches each pixel's RGB from the frame buffer read port, and classifies the pixel as green. It registers everything so that coordinates, colour and flag arrive aligned. It sits between the camera frame buffer and the color tracker.

## Interface
Parameters:
- H_ACTIVE, 640: active pixels per line.
- H_TOTAL, 800: pixel slots per line, including blanking.
- V_ACTIVE, 480: active lines per frame.
- V_TOTAL, 525: lines per frame, including blanking.
- G_MIN, 128: minimum G value for a pixel to count as green.
- G_MARGIN, 40: amount by which G must exceed both R and B.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: pixel strobe. All state advances only on clk edges where enable=1.
- run, in, 1: streaming request.
- rd_en, out, 1: frame buffer read request.
- rd_x, out, 10: frame buffer read column.
- rd_y, out, 10: frame buffer read row.
- rgb_in, in, 24: frame buffer data {R,G,B}, 8 bits each. Valid by the next enable after rd_en.
- x, out, 10: pixel column to the tracker.
- y, out, 10: pixel row to the tracker.
- R, out, 8: red component to the tracker.
- G, out, 8: green component to the tracker.
- B, out, 8: blue component to the tracker.
- verde, out, 1: green-classified active pixel.
- active, out, 1: the output slot is inside the active region.
- frame_start, out, 1: pulse with output pixel (0,0).
- frame_done, out, 1: pulse with output pixel (H_ACTIVE-1, V_ACTIVE-1).
- busy, out, 1: FSM is not IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters held at (0,0) and rd_en=0. Moves to RUN on an enable where run=1.
  - RUN: counters advance every enable. If run=0 is seen, moves to DRAIN.
  - DRAIN: continues the current frame. At the end of the frame, moves to IDLE.
    - End of frame is h=H_TOTAL-1 and v=V_TOTAL-1.
    - If run=1 is seen again before the end of the frame, returns to RUN and does not stop.
  - When RUN reaches the end of the frame with run=1, it wraps to (0,0) with no idle gap.
- Raster counters h and v:
  - h wraps at H_TOTAL-1 to 0.
  - v increments when h wraps, and wraps at V_TOTAL-1 to 0.
- Stage 0 (request): rd_en = (h<H_ACTIVE && v<V_ACTIVE && state!=IDLE), rd_x=h, rd_y=v.
  - Stage 0 also delays the coordinates and the active bit by one stage.
- Stage 1 (classify):
  - Captures rgb_in, the delayed coordinates and the active bit.
  - verde = active && G>=G_MIN && G>=R+G_MARGIN && G>=B+G_MARGIN.
  - The sums are evaluated at 9 bits. A sum above 255 makes its comparison false; it never wraps.
- Blanking slots:
  - x and y carry the raw counter values, for example x=700.
  - R, G and B are 0; verde and active are 0.
  - No blanking slot outputs (0,0), because v=0 blanking has h>=H_ACTIVE. The tracker's clear is therefore triggered exactly once per frame.
- IDLE outputs: x=0, y=0, R=G=B=0, verde=0, active=0.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, pipeline registers 0.
- Reset overrides enable and run, and is legal mid-frame.
- Latency is 2 enables from the counter value to the x/y/RGB/verde outputs. rd_* lead the outputs by 1 enable.
- The first enable in RUN after leaving IDLE outputs counter (0,0) two enables later. frame_start is high for that one enable slot.
- frame_start and frame_done each last exactly one enable slot: asserted at that enable and deasserted at the next.
- With enable=0, all outputs hold their values.
- On the IDLE transition, the last blanking slot drains through the pipeline. Outputs return to IDLE values 2 enables after the FSM reaches IDLE.

## Structure
- Package green_stream_pkg holds:
  - frame geometry constants;
  - the FSM state typedef (IDLE, RUN, DRAIN);
  - the pixel struct {x, y, r, g, b, active}.
- Sub-module raster_counter holds h/v counting, wrap and end-of-frame flags, with inputs enable, clear and advance.
- The top level holds the FSM, the 2-stage pipeline and the classifier.

## Test plan
- Reset mid-frame at h=300, v=200 -> next cycle all outputs 0, busy=0, rd_en=0.
- run=1 with a constant pixel {R=20, G=200, B=30} -> verde=1 on all 640x480 active outputs, verde=0 in blanking. frame_start exactly once per 420000 enables; frame_done coincides with x=639, y=479.
- Classifier boundaries:
  - G=128, R=88, B=88 -> verde=1.
  - G=127 -> 0.
  - G=200, R=161 -> 0.
  - R=230, G=255 -> 0, since 230+40 is above 255 and the comparison must not wrap.
- enable high only 1 cycle in 2 -> output sequence identical to the enable-always case; outputs hold steady between strobes.
- Drop run at v=100 -> frame completes, busy falls after (799, 524), exactly one frame_done. Re-asserting run at v=300 -> continuous next frame with no IDLE gap.
- Closed loop with the color tracker, columns 160-319 green -> after one frame only verde_detectado[1]=1.

Source files
------------

// File: rtl/green_stream_pkg.sv
// Shared geometry, FSM state type, pixel record and green classifier for the pixel streamer.
package green_stream_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_TOTAL  = 800;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_TOTAL  = 525;
    localparam int unsigned DEF_G_MIN    = 128;
    localparam int unsigned DEF_G_MARGIN = 40;
    localparam int unsigned COORD_W      = 10;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [7:0]         r;
        logic [7:0]         g;
        logic [7:0]         b;
        logic               active;
    } pixel_t;

    // Sums are widened to 9 bits so a margin pushing past 255 fails instead of wrapping.
    function automatic logic is_green(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b, input logic [7:0] g_min,
                                      input logic [7:0] g_margin);
        logic [8:0] r_sum;
        logic [8:0] b_sum;
        r_sum = {1'b0, r} + {1'b0, g_margin};
        b_sum = {1'b0, b} + {1'b0, g_margin};
        return (g >= g_min) && ({1'b0, g} >= r_sum) && ({1'b0, g} >= b_sum);
    endfunction

endpackage

// File: rtl/green_pixel_streamer_if.sv
// Frame buffer read port plus the aligned pixel stream toward the colour tracker.
interface green_pixel_streamer_if;
    import green_stream_pkg::*;

    logic               rd_en;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic [23:0]        rgb_in;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [7:0]         R;
    logic [7:0]         G;
    logic [7:0]         B;
    logic               verde;
    logic               active;
    logic               frame_start;
    logic               frame_done;

    modport master (
        output rd_en, rd_x, rd_y, x, y, R, G, B, verde, active, frame_start, frame_done,
        input  rgb_in
    );

    modport slave (
        input  rd_en, rd_x, rd_y, x, y, R, G, B, verde, active, frame_start, frame_done,
        output rgb_in
    );

endinterface

// File: rtl/raster_counter.sv
// Horizontal/vertical raster position with wrap and end-of-frame flag.
module raster_counter
    import green_stream_pkg::*;
#(
    parameter int unsigned H_TOTAL = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL = DEF_V_TOTAL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] h,
    output logic [COORD_W-1:0] v,
    output logic               eof
);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    logic h_last;
    logic v_last;

    assign h_last = (h == H_LAST);
    assign v_last = (v == V_LAST);
    assign eof    = h_last && v_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (enable) begin
            if (clear) begin
                h <= '0;
                v <= '0;
            end else if (advance) begin
                h <= h_last ? '0 : h + COORD_W'(1);
                if (h_last) v <= v_last ? '0 : v + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/green_pixel_streamer.sv
// Raster walker with a request stage and a classify stage feeding the colour tracker.
module green_pixel_streamer
    import green_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
    parameter int unsigned G_MIN    = DEF_G_MIN,
    parameter int unsigned G_MARGIN = DEF_G_MARGIN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   run,
    output logic                   busy,
    green_pixel_streamer_if.master px
);

    localparam logic [COORD_W-1:0] H_ACT     = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT     = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_ACT_END = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] V_ACT_END = COORD_W'(V_ACTIVE - 1);
    localparam logic [7:0]         GMIN      = 8'(G_MIN);
    localparam logic [7:0]         GMARGIN   = 8'(G_MARGIN);

    state_e             state;
    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] v;
    logic               eof;
    logic               req_act;

    logic               rd_en_q;
    logic [COORD_W-1:0] rd_x_q;
    logic [COORD_W-1:0] rd_y_q;
    pixel_t             out_q;
    logic               verde_q;
    logic               fs_q;
    logic               fd_q;

    raster_counter #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL)
    ) u_raster (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (state == StIdle),
        .advance(state != StIdle),
        .h      (h),
        .v      (v),
        .eof    (eof)
    );

    // Stopping only ever happens on the end-of-frame slot, so a frame is never cut short.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            busy  <= 1'b0;
        end else if (enable) begin
            unique case (state)
                StIdle: begin
                    if (run) begin
                        state <= StRun;
                        busy  <= 1'b1;
                    end
                end
                StRun: begin
                    if (!run) begin
                        if (eof) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (run) begin
                        state <= StRun;
                    end else if (eof) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_act = (h < H_ACT) && (v < V_ACT) && (state != StIdle);

    // Request stage: the read address doubles as the delayed coordinate/active pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en_q <= 1'b0;
            rd_x_q  <= '0;
            rd_y_q  <= '0;
        end else if (enable) begin
            rd_en_q <= req_act;
            rd_x_q  <= h;
            rd_y_q  <= v;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            verde_q <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else if (enable) begin
            out_q.x      <= rd_x_q;
            out_q.y      <= rd_y_q;
            out_q.active <= rd_en_q;
            {out_q.r, out_q.g, out_q.b} <= rd_en_q ? px.rgb_in : 24'h0;
            verde_q <= rd_en_q && is_green(px.rgb_in[23:16], px.rgb_in[15:8], px.rgb_in[7:0],
                                           GMIN, GMARGIN);
            fs_q    <= rd_en_q && (rd_x_q == '0) && (rd_y_q == '0);
            fd_q    <= rd_en_q && (rd_x_q == H_ACT_END) && (rd_y_q == V_ACT_END);
        end
    end

    assign px.rd_en       = rd_en_q;
    assign px.rd_x        = rd_x_q;
    assign px.rd_y        = rd_y_q;
    assign px.x           = out_q.x;
    assign px.y           = out_q.y;
    assign px.R           = out_q.r;
    assign px.G           = out_q.g;
    assign px.B           = out_q.b;
    assign px.verde       = verde_q;
    assign px.active      = out_q.active;
    assign px.frame_start = fs_q;
    assign px.frame_done  = fd_q;

endmodule
